// File: rtl/hyster.sv
`default_nettype none
// ============================================================================
// hyster: single-pass hysteresis threshold over a sliding 3x3 window.
// Revision: 1.0
// ============================================================================
module hyster #(
  parameter logic [4:0] HIGH_TH = 5'd16,
  parameter logic [4:0] LOW_TH  = 5'd8
) (
  input  logic       clk_p_i,
  input  logic       reset_p_i,
  input  logic [4:0] pixel_in0_i,
  input  logic [4:0] pixel_in1_i,
  input  logic [4:0] pixel_in2_i,
  input  logic       enable_i,
  output logic       pixel_out_o,
  output logic       readable_o
);

  // Column layout: index 0 = top row, 1 = middle row, 2 = bottom row.
  logic [2:0][4:0] col_a_q;
  logic [2:0][4:0] col_b_q;
  logic [2:0][4:0] w_col_c;
  logic [4:0]      w_centre;
  logic            w_nb_strong;
  logic            w_is_strong;
  logic            w_is_weak;
  logic            pixel_out_d;

  assign w_col_c  = {pixel_in2_i, pixel_in1_i, pixel_in0_i};
  assign w_centre = col_b_q[1];

  always_comb begin
    w_nb_strong = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (col_a_q[i] >= HIGH_TH) w_nb_strong = 1'b1;
      if (w_col_c[i] >= HIGH_TH) w_nb_strong = 1'b1;
      if ((i != 1) && (col_b_q[i] >= HIGH_TH)) w_nb_strong = 1'b1;
    end
  end

  always_comb begin
    w_is_strong = (w_centre >= HIGH_TH);
    w_is_weak   = (w_centre >= LOW_TH) && !w_is_strong;
    pixel_out_d = enable_i && (w_is_strong || (w_is_weak && w_nb_strong));
  end

  // The window shifts every edge so that columns presented with enable low prime it.
  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      col_a_q     <= '0;
      col_b_q     <= '0;
      pixel_out_o <= 1'b0;
      readable_o  <= 1'b0;
    end else begin
      col_a_q     <= col_b_q;
      col_b_q     <= w_col_c;
      pixel_out_o <= pixel_out_d;
      readable_o  <= enable_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hyster.sv
`default_nettype none
// Testbench for hyster: directed threshold cases plus a randomized strip
// checked against a window-level hysteresis reference model.
module tb_hyster;

  typedef logic [2:0][4:0] col_t;  // [0]=top, [1]=middle, [2]=bottom

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] p0, p1, p2;
  logic       en;
  wire        out;
  wire        rd;

  int n_tests = 0;
  int n_fail  = 0;

  col_t ma, mb;  // model's view of the two previously captured columns

  always #5 clk = ~clk;

  hyster dut (
    .clk_p_i     (clk),
    .reset_p_i   (rst),
    .pixel_in0_i (p0),
    .pixel_in1_i (p1),
    .pixel_in2_i (p2),
    .enable_i    (en),
    .pixel_out_o (out),
    .readable_o  (rd)
  );

  function automatic col_t mk(input int t, input int m, input int b);
    col_t c;
    c[0] = t[4:0];
    c[1] = m[4:0];
    c[2] = b[4:0];
    return c;
  endfunction

  // Reference: build the 3x3 window and apply the hysteresis rules directly.
  function automatic bit golden(input col_t a, input col_t b, input col_t c);
    int w[3][3];
    int p;
    for (int r = 0; r < 3; r++) begin
      w[r][0] = int'(a[r]);
      w[r][1] = int'(b[r]);
      w[r][2] = int'(c[r]);
    end
    p = w[1][1];
    if (p >= 16) return 1'b1;
    if (p < 8) return 1'b0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        if (!(r == 1 && k == 1) && w[r][k] >= 16) return 1'b1;
    return 1'b0;
  endfunction

  // Present one column, advance one clock, return the model's expected output.
  task automatic step(input col_t c, input bit e, output bit exp_out);
    p0 = c[0];
    p1 = c[1];
    p2 = c[2];
    en = e;
    exp_out = e ? golden(ma, mb, c) : 1'b0;
    @(posedge clk);
    #1;
    ma = mb;
    mb = c;
  endtask

  task automatic test_reset();
    bit x;
    n_tests++;
    if (rd !== 1'b0 || out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: rd=%b out=%b required rd=0 out=0", rd, out);
    end
    step(mk(0, 0, 0), 1'b0, x);
    step(mk(0, 20, 0), 1'b0, x);
    step(mk(20, 20, 20), 1'b1, x);
    n_tests++;
    if (rd !== 1'b1 || out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: rd=%b out=%b required rd=1 out=1", rd, out);
    end
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if (rd !== 1'b0 || out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: rd=%b out=%b required rd=0 out=0", rd, out);
    end
    #1;
    rst = 1'b0;
    ma = '0;
    mb = '0;
    step(mk(20, 20, 20), 1'b1, x);
    n_tests++;
    if (rd !== 1'b1 || out !== 1'b0 || x !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_window_cleared: rd=%b out=%b required rd=1 out=0", rd, out);
    end
  endtask

  task automatic test_strong_centre();
    bit x;
    step(mk(0, 0, 0), 1'b0, x);
    step(mk(0, 20, 0), 1'b0, x);
    step(mk(0, 0, 0), 1'b1, x);
    n_tests++;
    if (out !== 1'b1 || rd !== 1'b1) begin
      n_fail++;
      $display("FAIL strong_centre: out=%b rd=%b required out=1 rd=1", out, rd);
    end
  endtask

  task automatic test_weak_neighbour();
    bit x;
    step(mk(0, 0, 0), 1'b0, x);
    step(mk(0, 10, 0), 1'b0, x);
    step(mk(16, 0, 0), 1'b1, x);
    n_tests++;
    if (out !== 1'b1) begin
      n_fail++;
      $display("FAIL weak_nb16: out=%b required 1", out);
    end
    step(mk(0, 0, 0), 1'b0, x);
    step(mk(0, 10, 0), 1'b0, x);
    step(mk(15, 0, 0), 1'b1, x);
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL weak_nb15: out=%b required 0", out);
    end
  endtask

  task automatic test_boundaries();
    bit x;
    step(mk(0, 0, 0), 1'b0, x);
    step(mk(0, 8, 0), 1'b0, x);
    step(mk(0, 0, 16), 1'b1, x);
    n_tests++;
    if (out !== 1'b1) begin
      n_fail++;
      $display("FAIL centre8_nb16: out=%b required 1", out);
    end
    step(mk(31, 31, 31), 1'b0, x);
    step(mk(31, 7, 31), 1'b0, x);
    step(mk(31, 31, 31), 1'b1, x);
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL centre7_nb31: out=%b required 0", out);
    end
    step(mk(0, 0, 0), 1'b0, x);
    step(mk(0, 16, 0), 1'b0, x);
    step(mk(0, 0, 0), 1'b1, x);
    n_tests++;
    if (out !== 1'b1) begin
      n_fail++;
      $display("FAIL centre16_alone: out=%b required 1", out);
    end
    step(mk(0, 20, 0), 1'b0, x);
    step(mk(15, 7, 15), 1'b0, x);
    step(mk(0, 16, 0), 1'b1, x);
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL centre7_strong_row: out=%b required 0", out);
    end
  endtask

  task automatic test_streaming();
    bit   x, e;
    col_t c;
    int   n_rd = 0;
    int   bad  = 0;
    for (int i = 0; i < 906; i++) begin
      c = mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      e = (i >= 2);
      step(c, e, x);
      if (rd === 1'b1) n_rd++;
      n_tests++;
      if (rd !== e || out !== x) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL stream col %0d: rd=%b out=%b required rd=%b out=%b", i, rd, out, e, x);
        bad++;
      end
    end
    n_tests++;
    if (n_rd !== 904) begin
      n_fail++;
      $display("FAIL stream_count: readable cycles=%0d required 904", n_rd);
    end
  endtask

  task automatic test_enable_gating();
    bit   x, e;
    col_t c;
    for (int i = 0; i < 24; i++) begin
      c = mk($urandom_range(0, 31), $urandom_range(8, 31), $urandom_range(0, 31));
      e = (i >= 2) && (i != 12);
      if (i == 11) c = mk(0, 20, 0);  // strong centre for the gated cycle
      step(c, e, x);
      n_tests++;
      if (rd !== e || out !== x) begin
        n_fail++;
        $display("FAIL gate col %0d: rd=%b out=%b required rd=%b out=%b", i, rd, out, e, x);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    p0  = '0;
    p1  = '0;
    p2  = '0;
    ma  = '0;
    mb  = '0;
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_strong_centre();
    test_weak_neighbour();
    test_boundaries();
    test_streaming();
    test_enable_gating();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
